// File: rtl/sum_block_accumulator_if.sv
// ---------------------------------------------------------------------------
// sum_block_accumulator_if
// Bundles the two valid/ready channels of the block accumulator.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both high. A producer that raises valid keeps its
// data stable until that edge. The consumer may change ready at any time.
// The consumer never samples data while ready is low.
//
//   in_valid     upstream sum valid           (master -> slave)
//   in_ready     accumulator can take a sum   (slave  -> master)
//   in_sum       unsigned adder result        (master -> slave)
//   flush        close the current partial block, single-cycle pulse
//   out_valid    block result valid           (slave  -> master)
//   out_ready    downstream accepts result    (master -> slave)
//   out_total    saturated block total
//   out_count    samples in the block
//   out_overflow block total saturated
//   busy         samples held or result pending
// ---------------------------------------------------------------------------
interface sum_block_accumulator_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int CNT_WIDTH  = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH:0]   in_sum;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_total;
    logic [CNT_WIDTH-1:0]  out_count;
    logic                  out_overflow;
    logic                  busy;

    modport master (
        output in_valid, in_sum, flush, out_ready,
        input  in_ready, out_valid, out_total, out_count, out_overflow, busy
    );

    modport slave (
        input  in_valid, in_sum, flush, out_ready,
        output in_ready, out_valid, out_total, out_count, out_overflow, busy
    );
endinterface

// File: rtl/sum_block_accumulator.sv
// ---------------------------------------------------------------------------
// sum_block_accumulator
// Accumulates a stream of (DATA_WIDTH+1)-bit unsigned sums into blocks of
// BLOCK_LEN samples. The block total saturates at 2^ACC_WIDTH-1. A block is
// closed early by a flush pulse. Each closed block is held on the output
// channel until it is accepted.
//
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          slave side of sum_block_accumulator_if
//   dbg_state_o  current FSM state (0 = ACCUM, 1 = HOLD)
// ---------------------------------------------------------------------------
module sum_block_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int BLOCK_LEN  = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int CNT_WIDTH  = $clog2(BLOCK_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sum_block_accumulator_if.slave   bus,
    output logic                     dbg_state_o
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                state_q;
    logic [ACC_WIDTH-1:0]  acc_q,   acc_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q,   ovf_d;
    logic [ACC_WIDTH-1:0]  total_q;
    logic [CNT_WIDTH-1:0]  ocount_q;
    logic                  oovf_q;

    logic [ACC_WIDTH:0]    sum_ext;
    logic                  accept;
    logic                  close;

    // Next-state datapath for the ACCUM state. The sum is formed one bit
    // wider than the accumulator so the carry-out flags saturation.
    always_comb begin
        sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH - DATA_WIDTH){1'b0}}, bus.in_sum};
        accept  = bus.in_valid && (state_q == ACCUM);
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (accept) begin
            if (sum_ext[ACC_WIDTH]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_ext[ACC_WIDTH-1:0];
            end
            count_d = count_q + CNT_WIDTH'(1);
        end
        // Close on a full block, or on flush when the block would not be
        // empty (a sample accepted on the flush edge counts).
        close = (state_q == ACCUM) &&
                ((accept && (count_d == CNT_WIDTH'(BLOCK_LEN))) ||
                 (bus.flush && ((count_q != '0) || accept)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            total_q  <= '0;
            ocount_q <= '0;
            oovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    acc_q   <= acc_d;
                    count_q <= count_d;
                    ovf_q   <= ovf_d;
                    if (close) begin
                        state_q  <= HOLD;
                        total_q  <= acc_d;
                        ocount_q <= count_d;
                        oovf_q   <= ovf_d;
                    end
                end
                HOLD: begin
                    // Output fields keep their values after the hand-off;
                    // only the working block is cleared.
                    if (bus.out_ready) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == ACCUM);
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.out_total    = total_q;
    assign bus.out_count    = ocount_q;
    assign bus.out_overflow = oovf_q;
    assign bus.busy         = (count_q != '0) || (state_q == HOLD);
    assign dbg_state_o      = (state_q == HOLD);

endmodule

// File: tb/tb_sum_block_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_block_accumulator
// Two instances share one stimulus stream: dut_a uses a 10-bit accumulator
// (saturates on the 511 block) and dut_b a 16-bit one (does not). Each table
// row gives the inputs applied in a cycle and the outputs expected in that
// same cycle, sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_sum_block_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [8:0] in_sum = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       state_a, state_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sum_block_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(3)) if_a ();
    sum_block_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(3)) if_b ();

    assign if_a.in_valid  = in_valid;
    assign if_a.in_sum    = in_sum;
    assign if_a.flush     = flush;
    assign if_a.out_ready = out_ready;
    assign if_b.in_valid  = in_valid;
    assign if_b.in_sum    = in_sum;
    assign if_b.flush     = flush;
    assign if_b.out_ready = out_ready;

    sum_block_accumulator #(.DATA_WIDTH(8), .BLOCK_LEN(4), .ACC_WIDTH(10), .CNT_WIDTH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .dbg_state_o(state_a)
    );
    sum_block_accumulator #(.DATA_WIDTH(8), .BLOCK_LEN(4), .ACC_WIDTH(16), .CNT_WIDTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .dbg_state_o(state_b)
    );

    typedef struct {
        logic       v;
        logic [8:0] s;
        logic       fl;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        int         e_tot_a;
        int         e_tot_b;
        int         e_cnt;
        logic       e_ovf_a;
        logic       e_ovf_b;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input int s, input logic fl, input logic ordy,
                       input logic rdy, input logic ov, input int ta, input int tb,
                       input int cnt, input logic oa, input logic ob, input logic busy);
        vec_t r;
        r.v = v; r.s = 9'(s); r.fl = fl; r.ordy = ordy;
        r.e_rdy = rdy; r.e_ov = ov; r.e_tot_a = ta; r.e_tot_b = tb;
        r.e_cnt = cnt; r.e_ovf_a = oa; r.e_ovf_b = ob; r.e_busy = busy;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic rdy, input logic ov, input int ta,
                             input int tb, input int cnt, input logic oa, input logic ob,
                             input logic busy);
        chk("a.in_ready",  idx, int'(if_a.in_ready),     int'(rdy));
        chk("a.out_valid", idx, int'(if_a.out_valid),    int'(ov));
        chk("a.state",     idx, int'(state_a),           int'(ov));
        chk("a.total",     idx, int'(if_a.out_total),    ta);
        chk("a.count",     idx, int'(if_a.out_count),    cnt);
        chk("a.overflow",  idx, int'(if_a.out_overflow), int'(oa));
        chk("a.busy",      idx, int'(if_a.busy),         int'(busy));
        chk("b.in_ready",  idx, int'(if_b.in_ready),     int'(rdy));
        chk("b.out_valid", idx, int'(if_b.out_valid),    int'(ov));
        chk("b.state",     idx, int'(state_b),           int'(ov));
        chk("b.total",     idx, int'(if_b.out_total),    tb);
        chk("b.count",     idx, int'(if_b.out_count),    cnt);
        chk("b.overflow",  idx, int'(if_b.out_overflow), int'(ob));
        chk("b.busy",      idx, int'(if_b.busy),         int'(busy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int s, input logic fl, input logic ordy);
        in_valid  = v;
        in_sum    = 9'(s);
        flush     = fl;
        out_ready = ordy;
    endtask

    initial begin
        // Block of adder outputs: 7+7+18+25 = 57
        add(1, 7,   0, 1,  1, 0, 0,    0,    0, 0, 0, 0);
        add(1, 7,   0, 1,  1, 0, 0,    0,    0, 0, 0, 1);
        add(1, 18,  0, 1,  1, 0, 0,    0,    0, 0, 0, 1);
        add(1, 25,  0, 1,  1, 0, 0,    0,    0, 0, 0, 1);
        add(0, 0,   0, 1,  0, 1, 57,   57,   4, 0, 0, 1);
        // Saturation: 4 x 511 = 2044, clips to 1023 in the 10-bit instance
        add(1, 511, 0, 1,  1, 0, 57,   57,   4, 0, 0, 0);
        add(1, 511, 0, 1,  1, 0, 57,   57,   4, 0, 0, 1);
        add(1, 511, 0, 1,  1, 0, 57,   57,   4, 0, 0, 1);
        add(1, 511, 0, 1,  1, 0, 57,   57,   4, 0, 0, 1);
        add(0, 0,   0, 1,  0, 1, 1023, 2044, 4, 1, 0, 1);
        // Next block starts with cleared overflow: 1+1+1+1 = 4
        add(1, 1,   0, 1,  1, 0, 1023, 2044, 4, 1, 0, 0);
        add(1, 1,   0, 1,  1, 0, 1023, 2044, 4, 1, 0, 1);
        add(1, 1,   0, 1,  1, 0, 1023, 2044, 4, 1, 0, 1);
        add(1, 1,   0, 1,  1, 0, 1023, 2044, 4, 1, 0, 1);
        add(0, 0,   0, 1,  0, 1, 4,    4,    4, 0, 0, 1);
        // Backpressure: 0+15+25+15 = 55, held while upstream keeps offering 99
        add(1, 0,   0, 0,  1, 0, 4,    4,    4, 0, 0, 0);
        add(1, 15,  0, 0,  1, 0, 4,    4,    4, 0, 0, 1);
        add(1, 25,  0, 0,  1, 0, 4,    4,    4, 0, 0, 1);
        add(1, 15,  0, 0,  1, 0, 4,    4,    4, 0, 0, 1);
        add(1, 99,  0, 0,  0, 1, 55,   55,   4, 0, 0, 1);
        add(1, 99,  0, 0,  0, 1, 55,   55,   4, 0, 0, 1);
        add(1, 99,  0, 0,  0, 1, 55,   55,   4, 0, 0, 1);
        add(1, 99,  0, 1,  0, 1, 55,   55,   4, 0, 0, 1);
        add(0, 0,   0, 1,  1, 0, 55,   55,   4, 0, 0, 0);
        // Flush alone after 7, 7 -> 14 / 2; flush in HOLD ignored
        add(1, 7,   0, 1,  1, 0, 55,   55,   4, 0, 0, 0);
        add(1, 7,   0, 1,  1, 0, 55,   55,   4, 0, 0, 1);
        add(0, 0,   1, 0,  1, 0, 55,   55,   4, 0, 0, 1);
        add(0, 0,   1, 0,  0, 1, 14,   14,   2, 0, 0, 1);
        add(0, 0,   0, 1,  0, 1, 14,   14,   2, 0, 0, 1);
        // Flush on an empty block is ignored
        add(0, 0,   1, 1,  1, 0, 14,   14,   2, 0, 0, 0);
        add(0, 0,   0, 1,  1, 0, 14,   14,   2, 0, 0, 0);
        // Flush with the third sample: 7+7+18 = 32 / 3
        add(1, 7,   0, 1,  1, 0, 14,   14,   2, 0, 0, 0);
        add(1, 7,   0, 1,  1, 0, 14,   14,   2, 0, 0, 1);
        add(1, 18,  1, 1,  1, 0, 14,   14,   2, 0, 0, 1);
        add(0, 0,   0, 0,  0, 1, 32,   32,   3, 0, 0, 1);
        // Sample + flush offered during HOLD must not be taken
        add(1, 5,   1, 1,  0, 1, 32,   32,   3, 0, 0, 1);
        // Single-sample block: accept + flush on an empty block
        add(1, 5,   1, 1,  1, 0, 32,   32,   3, 0, 0, 0);
        add(0, 0,   0, 1,  0, 1, 5,    5,    1, 0, 0, 1);
        add(0, 0,   0, 1,  1, 0, 5,    5,    1, 0, 0, 0);

        // Reset, released between edges
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            check_all(i, vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_tot_a, vecs[i].e_tot_b,
                      vecs[i].e_cnt, vecs[i].e_ovf_a, vecs[i].e_ovf_b, vecs[i].e_busy);
            drive(vecs[i].v, int'(vecs[i].s), vecs[i].fl, vecs[i].ordy);
            step();
        end

        // Async reset after two accepts mid-block
        drive(1, 3, 0, 1);
        step();
        drive(1, 4, 0, 1);
        step();
        drive(0, 0, 0, 1);
        check_all(100, 1, 0, 5, 5, 1, 0, 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all(101, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        // Fresh block 1+2+3+4 = 10
        for (int k = 1; k <= 4; k++) begin
            drive(1, k, 0, 1);
            step();
        end
        drive(0, 0, 0, 1);
        check_all(102, 0, 1, 10, 10, 4, 0, 0, 1);
        step();
        check_all(103, 1, 0, 10, 10, 4, 0, 0, 0);

        // Async reset while a result is pending
        for (int k = 1; k <= 4; k++) begin
            drive(1, 10 * k, 0, 0);
            step();
        end
        drive(0, 0, 0, 0);
        check_all(104, 0, 1, 100, 100, 4, 0, 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all(105, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        check_all(106, 1, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_block_accumulator.md
Name: sum_block_accumulator

Overview:
Downstream consumer of the parameterised fullAdder result bus. Accepts a stream of (DATA_WIDTH+1)-bit sums over a valid/ready handshake and accumulates them into fixed-length blocks of BLOCK_LEN samples. Presents each block total, sample count and overflow flag on an output valid/ready handshake. Supports early flush of a partial block.

Parameters:
DATA_WIDTH, 8, operand width of the upstream adder; input sum is DATA_WIDTH+1 bits
BLOCK_LEN, 4, samples per block; legal range >= 1
ACC_WIDTH, 16, accumulator/output total width; must be >= DATA_WIDTH+1
CNT_WIDTH, $clog2(BLOCK_LEN+1), width of sample count

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream sum valid
in_ready  output  1  block can accept a sum this cycle
in_sum  input  DATA_WIDTH+1  unsigned sum from the adder stage
flush  input  1  close current partial block (single-cycle pulse)
out_valid  output  1  block result valid
out_ready  input  1  downstream accepts result
out_total  output  ACC_WIDTH  block total, saturated
out_count  output  CNT_WIDTH  samples in the block (1..BLOCK_LEN)
out_overflow  output  1  block total saturated
busy  output  1  at least one sample held in current block, or result pending

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low. Reset forces state ACCUM, acc=0, count=0, ovf=0, out_valid=0, out_total=0, out_count=0, out_overflow=0, busy=0. in_ready=1 in the first cycle after reset release.
- FSM, two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept in ACCUM: a sample is accepted when in_valid && in_ready at a rising edge.
  - in_sum is zero-extended to ACC_WIDTH+1 and added to acc.
  - If the result exceeds 2^ACC_WIDTH-1, acc = all-ones and ovf is set sticky for the block.
  - count increments on each accept.
- ACCUM -> HOLD when either:
  - the accepted sample makes count==BLOCK_LEN; or
  - flush=1 and (count>0 or a sample is accepted the same edge).
- Flush with a simultaneous accept includes that sample, then closes the block. Flush in ACCUM with count==0 and no accept is ignored. Flush in HOLD is ignored.
- Entering HOLD: out_total, out_count and out_overflow register the final acc, count and ovf. Latency is 1 cycle: out_valid is high in the cycle after the edge that accepted the last sample.
- HOLD: out_total, out_count and out_overflow stay stable until out_valid && out_ready. On that edge: acc=0, count=0, ovf=0, state returns to ACCUM, out_valid=0. Output data fields retain their last values.
- No pass-through: in_sum is never accepted in HOLD, so minimum block period is BLOCK_LEN+1 cycles.
- busy = (count!=0) || (state==HOLD).
- in_valid while in_ready=0 has no effect. Upstream must hold data; this block does not sample it.
- Async reset mid-block or in HOLD discards all partial or pending results immediately (no clock needed).
- Arithmetic is unsigned only; no wrap-around ever occurs in out_total.

Test Plan:
- Block of adder outputs: DATA_WIDTH=8, BLOCK_LEN=4, ACC_WIDTH=16; sums 7, 7, 18, 25 on consecutive cycles with out_ready=1 -> one cycle later out_valid=1, out_total=57, out_count=4, out_overflow=0; next cycle in_ready=1, busy=0.
- Saturation: ACC_WIDTH=10, sums 511, 511, 511, 511 -> out_total=1023, out_overflow=1, out_count=4. The following block of 1, 1, 1, 1 -> out_total=4, out_overflow=0.
- Backpressure: complete block 0, 15, 25, 15 with out_ready=0 for 3 cycles while in_valid=1 -> out_valid stays 1, out_total=55 stable, in_ready=0, no sample counted. After out_ready=1, the next block starts empty.
- Flush: accept 7 and 7, pulse flush alone -> out_total=14, out_count=2. Flush with count=0 -> no out_valid. Flush together with a third accepted sum of 18 -> out_total=32, out_count=3.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously (between edges) after 2 accepts -> all outputs go to 0 immediately. After release, a full block of 1, 2, 3, 4 -> out_total=10.
  - Repeat with the reset asserted during HOLD -> out_valid drops immediately.
